// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//
// Mealy serial-pattern detector with a runtime-loadable pattern of 1..PAT_W
// bits. Each enabled cycle consumes one bit of the serial stream. The match
// pulse is combinational in the same cycle as the final pattern bit. A
// saturating counter tallies matches.
//
// Parameters
//   PAT_W    maximum pattern length in bits (>= 2)
//   CNT_W    match counter width
//   RST_PAT  pattern loaded at reset
//   RST_LEN  pattern length loaded at reset (1..PAT_W)
//
// Ports
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   en         stream-bit qualifier; i is consumed only when en=1
//   i          serial data bit
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   load       pattern-load strobe; has priority over streaming
//   pat_in     new pattern; bit len-1 is the first bit received
//   len_in     new pattern length (0 is clamped to 1, >PAT_W to PAT_W)
//   clr_cnt    synchronous clear of match_cnt; wins over a same-cycle hit
//   o          Mealy match pulse
//   match_cnt  saturating match count
//   pat_q      active pattern
//   len_q      active pattern length
// -----------------------------------------------------------------------------
module seq_detector #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1101,
    parameter int               RST_LEN = 4,
    localparam int              LW      = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             i,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LW-1:0]    len_in,
    input  logic             clr_cnt,
    output logic             o,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pat_q,
    output logic [LW-1:0]    len_q
);

    // History of previously consumed bits, newest in bit 0, and how many of
    // them are valid since the last reset, load or non-overlapping match.
    logic [PAT_W-2:0] hist;
    logic [LW-1:0]    fill;

    logic [PAT_W-2:0] hist_d;
    logic [LW-1:0]    fill_d;
    logic [PAT_W-1:0] pat_d;
    logic [LW-1:0]    len_d;
    logic [CNT_W-1:0] cnt_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             hit;

    // The candidate window is the stored history with the live input bit
    // appended; only the low len_q bits take part in the comparison.
    always_comb begin
        window = {hist, i};
        for (int k = 0; k < PAT_W; k++) begin
            mask[k] = (LW'(k) < len_q);
        end
    end

    // len_q is never 0, so len_q-1 cannot underflow.
    assign hit = en && !load
              && (fill >= len_q - LW'(1))
              && (((window ^ pat_q) & mask) == '0);

    assign o = hit;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        hist_d = hist;
        fill_d = fill;
        pat_d  = pat_q;
        len_d  = len_q;
        cnt_d  = match_cnt;

        if (load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
            if (len_in == '0) begin
                len_d = LW'(1);
            end else if (len_in > LW'(PAT_W)) begin
                len_d = LW'(PAT_W);
            end else begin
                len_d = len_in;
            end
        end else if (en) begin
            if (hit && !overlap) begin
                // Non-overlapping: the next match must be built from fresh bits.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                fill_d = (fill == LW'(PAT_W - 1)) ? fill : fill + LW'(1);
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (match_cnt != '1)) begin
            cnt_d = match_cnt + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist      <= '0;
            fill      <= '0;
            pat_q     <= RST_PAT;
            len_q     <= LW'(RST_LEN);
            match_cnt <= '0;
        end else begin
            hist      <= hist_d;
            fill      <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            match_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_detector
//
// Self-checking bench for seq_detector with default parameters. A queue-based
// reference model holds the bits consumed since the last reset, load or
// non-overlapping match and decides matches directly from the pattern rules.
// Inputs change 1 ns after the rising edge; outputs are compared at the
// falling edge, where the Mealy output has settled.
// -----------------------------------------------------------------------------
module tb_seq_detector;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             en;
    logic             i;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic [LW-1:0]    len_in;
    logic             clr_cnt;
    logic             o;
    logic [CNT_W-1:0] match_cnt;
    logic [PAT_W-1:0] pat_q;
    logic [LW-1:0]    len_q;

    int checks = 0;
    int errors = 0;

    seq_detector dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (en),
        .i         (i),
        .overlap   (overlap),
        .load      (load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .clr_cnt   (clr_cnt),
        .o         (o),
        .match_cnt (match_cnt),
        .pat_q     (pat_q),
        .len_q     (len_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit               q[$];      // consumed bits, newest at the back
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    int               m_cnt;

    function automatic void model_reset();
        q.delete();
        m_pat = 4'b1101;
        m_len = 4;
        m_cnt = 0;
    endfunction

    // A match: the live bit followed backwards by the stored bits reproduces
    // pattern bits 0, 1, ..., len-1.
    function automatic bit model_hit();
        if (!n_rst || !en || load) return 1'b0;
        if (q.size() < m_len - 1) return 1'b0;
        for (int j = 0; j < m_len; j++) begin
            bit b;
            b = (j == 0) ? i : q[q.size() - j];
            if (b != m_pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_update(input bit hit);
        if (load) begin
            m_pat = pat_in;
            if (len_in == 0)          m_len = 1;
            else if (len_in > PAT_W)  m_len = PAT_W;
            else                      m_len = int'(len_in);
            q.delete();
        end else if (en) begin
            if (hit && !overlap) begin
                q.delete();
            end else begin
                q.push_back(i);
                if (q.size() > PAT_W - 1) void'(q.pop_front());
            end
        end
        if (clr_cnt)                 m_cnt = 0;
        else if (hit && m_cnt < CMAX) m_cnt++;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called 1 ns after a rising edge with the inputs already set.
    task automatic tick();
        bit exp_o;
        #4;
        exp_o = model_hit();
        check("o", o, exp_o);
        check("match_cnt", match_cnt, m_cnt);
        check("pat_q", pat_q, m_pat);
        check("len_q", len_q, m_len);
        @(posedge clk);
        model_update(exp_o);
        #1;
    endtask

    task automatic feed(input bit b);
        en = 1'b1; i = b; load = 1'b0; clr_cnt = 1'b0;
        tick();
    endtask

    task automatic feed_word(input logic [6:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) feed(bits[k]);
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [LW-1:0] l);
        load = 1'b1; pat_in = p; len_in = l; en = 1'b1; i = 1'(($urandom));
        clr_cnt = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic clear_cnt();
        en = 1'b0; load = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // Asserts reset asynchronously, checks reset values mid-reset, and
    // releases it away from the rising edge.
    task automatic do_reset();
        en = 1'b1; i = 1'b1; load = 1'b0; clr_cnt = 1'b0;
        n_rst = 1'b0;
        model_reset();
        #2;
        check("rst_o", o, 1'b0);
        check("rst_cnt", match_cnt, 0);
        check("rst_pat", pat_q, 4'b1101);
        check("rst_len", len_q, 4);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = 1'b0; i = 1'b0; overlap = 1'b1; load = 1'b0;
        pat_in = '0; len_in = '0; clr_cnt = 1'b0; n_rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Default pattern 1101, overlapping: hits on bits 4 and 7.
        do_reset();
        overlap = 1'b1;
        feed_word(7'b1101101, 7);
        check("ovl_cnt", match_cnt, 2);

        // Same stream, non-overlapping: hit on bit 4 only.
        do_reset();
        overlap = 1'b0;
        feed_word(7'b1101101, 7);
        check("novl_cnt", match_cnt, 1);

        // Three-bit pattern 101.
        do_load(4'b0101, 3'd3);
        check("ld_pat", pat_q, 4'b0101);
        check("ld_len", len_q, 3);
        check("ld_cnt_kept", match_cnt, 1);
        clear_cnt();
        overlap = 1'b1;
        feed_word(7'b0010101, 5);
        check("p101_ovl_cnt", match_cnt, 2);
        do_load(4'b0101, 3'd3);
        clear_cnt();
        overlap = 1'b0;
        feed_word(7'b0010101, 5);
        check("p101_novl_cnt", match_cnt, 1);

        // Length 0 clamps to 1; o follows i.
        do_load(4'b1111, 3'd0);
        check("len0_len", len_q, 1);
        overlap = 1'b1;
        for (int k = 0; k < 8; k++) feed(1'(k % 3 == 0));

        // Length above PAT_W clamps to PAT_W.
        do_load(4'b1010, 3'd7);
        check("len7_len", len_q, PAT_W);

        // en gating: idle cycles with toggling input hold history.
        do_reset();
        overlap = 1'b1;
        feed_word(7'b0000110, 3);
        for (int k = 0; k < 4; k++) begin
            en = 1'b0; i = 1'(k);
            tick();
        end
        feed(1'b1);
        check("gate_cnt", match_cnt, 1);

        // Saturation with single-bit pattern 1, then clear beats a hit.
        do_load(4'b0001, 3'd1);
        clear_cnt();
        overlap = 1'b1;
        for (int k = 0; k < CMAX + 5; k++) feed(1'b1);
        check("sat_cnt", match_cnt, CMAX);
        en = 1'b1; i = 1'b1; clr_cnt = 1'b1;
        #4;
        check("clr_hit_o", o, 1'b1);
        @(posedge clk);
        model_update(1'b1);
        #1;
        clr_cnt = 1'b0;
        check("clr_wins", match_cnt, 0);

        // Reset mid-pattern aborts the partial match.
        overlap = 1'b1;
        do_load(4'b1101, 3'd4);
        clear_cnt();
        feed_word(7'b0000110, 3);
        do_reset();
        feed(1'b1);
        check("midrst_cnt0", match_cnt, 0);
        feed_word(7'b0001101, 4);
        check("midrst_cnt1", match_cnt, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            en      = ($urandom_range(0, 9) != 0);
            i       = 1'($urandom);
            clr_cnt = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 39) == 0);
            pat_in  = PAT_W'($urandom);
            len_in  = LW'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) overlap = ~overlap;
            tick();
        end
        load = 1'b0; clr_cnt = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
